// File: rtl/data_queue_5x65_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_queue_5x65_pkg
// Brief    : Shared sizes and pointer helper for the 5x65 data queue.
// Revision : 1.0 - initial release
// ============================================================================
package data_queue_5x65_pkg;

  localparam int DEPTH = 5;
  localparam int WIDTH = 65;
  localparam int PTR_W = 3;
  localparam int CNT_W = 3;

  // Advance a row pointer by one, wrapping from the last row back to row 0
  // so that the pointer never takes the unused encodings 5..7.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_queue_5x65_if.sv
`default_nettype none
// ============================================================================
// Module   : data_queue_5x65_if
// Brief    : Enqueue / dequeue / flush bundle of the 5x65 data queue.
//            master = producer/consumer side, slave = queue side.
// Revision : 1.0 - initial release
// ============================================================================
interface data_queue_5x65_if;
  import data_queue_5x65_pkg::*;

  logic             io_enq_valid;
  logic             io_enq_ready;
  logic [WIDTH-1:0] io_enq_bits;
  logic             io_deq_valid;
  logic             io_deq_ready;
  logic [WIDTH-1:0] io_deq_bits;
  logic             io_flush;
  logic [CNT_W-1:0] io_count;

  modport master (
    output io_enq_valid,
    output io_enq_bits,
    output io_deq_ready,
    output io_flush,
    input  io_enq_ready,
    input  io_deq_valid,
    input  io_deq_bits,
    input  io_count
  );

  modport slave (
    input  io_enq_valid,
    input  io_enq_bits,
    input  io_deq_ready,
    input  io_flush,
    output io_enq_ready,
    output io_deq_valid,
    output io_deq_bits,
    output io_count
  );

endinterface
`default_nettype wire

// File: rtl/ram_data_5x65.sv
`default_nettype none
// ============================================================================
// Module   : ram_data_5x65
// Brief    : 5x65 storage, synchronous write port, combinational read port.
//            Contents are intentionally not reset.
// Revision : 1.0 - initial release
// ============================================================================
module ram_data_5x65
  import data_queue_5x65_pkg::*;
(
  input  wire logic [PTR_W-1:0] r0_addr_i,
  input  wire logic             r0_en_i,
  input  wire logic             r0_clk_i,
  output logic      [WIDTH-1:0] r0_data_o,
  input  wire logic [PTR_W-1:0] w0_addr_i,
  input  wire logic             w0_en_i,
  input  wire logic             w0_clk_i,
  input  wire logic [WIDTH-1:0] w0_data_i
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // The read port is purely combinational, so its clock has no load.
  wire w_unused_r0_clk = r0_clk_i;

  // Write the addressed row; out-of-range addresses write nothing.
  always_ff @(posedge w0_clk_i) begin
    for (int r = 0; r < DEPTH; r++) begin
      if (w0_en_i && (w0_addr_i == PTR_W'(r))) begin
        mem_q[r] <= w0_data_i;
      end
    end
  end

  // Zero-latency read of the addressed row; zero when disabled or out of range.
  always_comb begin
    r0_data_o = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (r0_en_i && (r0_addr_i == PTR_W'(r))) begin
        r0_data_o = mem_q[r];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/data_queue_5x65.sv
`default_nettype none
// ============================================================================
// Module   : data_queue_5x65
// Brief    : 5-entry x 65-bit FIFO. Head/tail/count control is flat here,
//            entries live in ram_data_5x65. Flush has priority over both
//            enqueue and dequeue; no pass-through or bypass paths.
// Revision : 1.0 - initial release
// ============================================================================
module data_queue_5x65
  import data_queue_5x65_pkg::*;
(
  input  wire logic        clock,
  input  wire logic        reset,
  data_queue_5x65_if.slave q
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic w_enq_ready;
  logic w_deq_valid;
  logic w_enq_fire;
  logic w_deq_fire;

  // Handshake qualifiers come from registered count and flush only, so
  // readiness never depends on the consumer (no full-queue pass-through).
  assign w_enq_ready = (count_q < CNT_W'(DEPTH)) && !q.io_flush;
  assign w_deq_valid = (count_q != '0) && !q.io_flush;
  assign w_enq_fire  = q.io_enq_valid && w_enq_ready;
  assign w_deq_fire  = w_deq_valid && q.io_deq_ready;

  assign q.io_enq_ready = w_enq_ready;
  assign q.io_deq_valid = w_deq_valid;
  assign q.io_count     = count_q;

  // Next-state for pointers and occupancy; flush clears everything.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (q.io_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (w_enq_fire) begin
        tail_d = ptr_inc(tail_q);
      end
      if (w_deq_fire) begin
        head_d = ptr_inc(head_q);
      end
      count_d = count_q + CNT_W'(w_enq_fire) - CNT_W'(w_deq_fire);
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Tail row is written only on enqueue fire, which is blocked when full,
  // so a write can never land on the row currently presented at the head.
  ram_data_5x65 u_ram (
    .r0_addr_i (head_q),
    .r0_en_i   (w_deq_valid),
    .r0_clk_i  (clock),
    .r0_data_o (q.io_deq_bits),
    .w0_addr_i (tail_q),
    .w0_en_i   (w_enq_fire),
    .w0_clk_i  (clock),
    .w0_data_i (q.io_enq_bits)
  );

endmodule
`default_nettype wire

// File: tb/tb_data_queue_5x65.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_queue_5x65
// Brief    : Directed self-checking bench for data_queue_5x65.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_queue_5x65;
  import data_queue_5x65_pkg::*;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  data_queue_5x65_if qif ();

  data_queue_5x65 dut (
    .clock (clock),
    .reset (reset),
    .q     (qif)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    qif.io_enq_valid = 1'b0;
    qif.io_enq_bits  = '0;
    qif.io_deq_ready = 1'b0;
    qif.io_flush     = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    #2;
    tests_run++;
    if (qif.io_enq_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_enq_ready got=%b exp=1", qif.io_enq_ready);
    end
    tests_run++;
    if (qif.io_deq_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_deq_valid got=%b exp=0", qif.io_deq_valid);
    end
    tests_run++;
    if (qif.io_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL reset_count got=%0d exp=0", qif.io_count);
    end
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Enqueue base+1..base+5 with the consumer stalled; checks occupancy rise.
  task automatic test_fill(input logic [WIDTH-1:0] base);
    for (int i = 1; i <= DEPTH; i++) begin
      qif.io_enq_valid = 1'b1;
      qif.io_enq_bits  = base + WIDTH'(i);
      qif.io_deq_ready = 1'b0;
      #1;
      tests_run++;
      if (qif.io_enq_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL fill_enq_ready[%0d] got=%b exp=1", i, qif.io_enq_ready);
      end
      tick();
      tests_run++;
      if (qif.io_count !== 3'(i)) begin
        tests_failed++;
        $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, qif.io_count, i);
      end
    end
    // Sixth offer while full must be refused.
    qif.io_enq_bits = base + 65'd6;
    #1;
    tests_run++;
    if (qif.io_enq_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL full_enq_ready got=%b exp=0", qif.io_enq_ready);
    end
    tick();
    qif.io_enq_valid = 1'b0;
    tests_run++;
    if (qif.io_count !== 3'd5) begin
      tests_failed++;
      $display("FAIL full_count_hold got=%0d exp=5", qif.io_count);
    end
  endtask

  // Drain n entries expecting base+1..base+n in order, then expect empty.
  task automatic test_drain(input logic [WIDTH-1:0] base, input int n);
    for (int i = 1; i <= n; i++) begin
      qif.io_enq_valid = 1'b0;
      qif.io_deq_ready = 1'b1;
      #1;
      tests_run++;
      if (qif.io_deq_valid !== 1'b1 || qif.io_deq_bits !== base + WIDTH'(i)) begin
        tests_failed++;
        $display("FAIL drain[%0d] valid=%b bits=%h exp_bits=%h", i,
                 qif.io_deq_valid, qif.io_deq_bits, base + WIDTH'(i));
      end
      tick();
    end
    qif.io_deq_ready = 1'b0;
    #1;
    tests_run++;
    if (qif.io_deq_valid !== 1'b0 || qif.io_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL drain_empty valid=%b count=%0d exp valid=0 count=0",
               qif.io_deq_valid, qif.io_count);
    end
  endtask

  task automatic test_wrap();
    logic [WIDTH-1:0] big;
    big = 65'h1_FFFF_FFFF_FFFF_FFFF;
    // Move head and tail to row 3.
    for (int i = 1; i <= 3; i++) begin
      qif.io_enq_valid = 1'b1;
      qif.io_enq_bits  = 65'h10 + WIDTH'(i);
      tick();
    end
    qif.io_enq_valid = 1'b0;
    test_drain(65'h10, 3);
    // Five writes now cover rows 3,4,0,1,2.
    for (int i = 1; i <= DEPTH; i++) begin
      qif.io_enq_valid = 1'b1;
      qif.io_enq_bits  = big;
      tick();
    end
    qif.io_enq_valid = 1'b0;
    tests_run++;
    if (qif.io_count !== 3'd5) begin
      tests_failed++;
      $display("FAIL wrap_count got=%0d exp=5", qif.io_count);
    end
    for (int i = 1; i <= DEPTH; i++) begin
      qif.io_deq_ready = 1'b1;
      #1;
      tests_run++;
      if (qif.io_deq_valid !== 1'b1 || qif.io_deq_bits !== big) begin
        tests_failed++;
        $display("FAIL wrap_deq[%0d] valid=%b bits=%h exp_bits=%h", i,
                 qif.io_deq_valid, qif.io_deq_bits, big);
      end
      tick();
    end
    qif.io_deq_ready = 1'b0;
    #1;
    tests_run++;
    if (qif.io_count !== 3'd0) begin
      tests_failed++;
      $display("FAIL wrap_final_count got=%0d exp=0", qif.io_count);
    end
  endtask

  task automatic test_full_simul();
    test_fill(65'h20);
    // Full: both sides active, only the dequeue may fire.
    qif.io_enq_valid = 1'b1;
    qif.io_enq_bits  = 65'h26;
    qif.io_deq_ready = 1'b1;
    #1;
    tests_run++;
    if (qif.io_enq_ready !== 1'b0 || qif.io_deq_bits !== 65'h21) begin
      tests_failed++;
      $display("FAIL simul_full enq_ready=%b bits=%h exp enq_ready=0 bits=21",
               qif.io_enq_ready, qif.io_deq_bits);
    end
    tick();
    tests_run++;
    if (qif.io_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL simul_count_after_deq got=%0d exp=4", qif.io_count);
    end
    qif.io_deq_ready = 1'b0;
    #1;
    tests_run++;
    if (qif.io_enq_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL simul_enq_ready_retry got=%b exp=1", qif.io_enq_ready);
    end
    tick();
    qif.io_enq_valid = 1'b0;
    tests_run++;
    if (qif.io_count !== 3'd5) begin
      tests_failed++;
      $display("FAIL simul_count_refill got=%0d exp=5", qif.io_count);
    end
    test_drain(65'h21, 5);
  endtask

  task automatic test_flush();
    for (int i = 1; i <= 3; i++) begin
      qif.io_enq_valid = 1'b1;
      qif.io_enq_bits  = 65'h30 + WIDTH'(i);
      tick();
    end
    qif.io_enq_valid = 1'b1;
    qif.io_enq_bits  = 65'h99;
    qif.io_deq_ready = 1'b1;
    qif.io_flush     = 1'b1;
    #1;
    tests_run++;
    if (qif.io_enq_ready !== 1'b0 || qif.io_deq_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_handshake enq_ready=%b deq_valid=%b exp 0 0",
               qif.io_enq_ready, qif.io_deq_valid);
    end
    tick();
    idle_inputs();
    tests_run++;
    if (qif.io_count !== 3'd0 || qif.io_deq_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL flush_empty count=%0d deq_valid=%b exp 0 0",
               qif.io_count, qif.io_deq_valid);
    end
    qif.io_enq_valid = 1'b1;
    qif.io_enq_bits  = 65'h44;
    tick();
    qif.io_enq_valid = 1'b0;
    tests_run++;
    if (qif.io_count !== 3'd1) begin
      tests_failed++;
      $display("FAIL flush_reenq_count got=%0d exp=1", qif.io_count);
    end
    test_drain(65'h43, 1);
  endtask

  task automatic test_async_reset();
    for (int i = 1; i <= 4; i++) begin
      qif.io_enq_valid = 1'b1;
      qif.io_enq_bits  = 65'h50 + WIDTH'(i);
      tick();
    end
    qif.io_enq_valid = 1'b0;
    tests_run++;
    if (qif.io_count !== 3'd4) begin
      tests_failed++;
      $display("FAIL areset_pre_count got=%0d exp=4", qif.io_count);
    end
    // Mid-cycle assertion: outputs must clear before any clock edge.
    #2;
    reset = 1'b1;
    #1;
    tests_run++;
    if (qif.io_count !== 3'd0 || qif.io_deq_valid !== 1'b0 || qif.io_enq_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL areset_immediate count=%0d deq_valid=%b enq_ready=%b exp 0 0 1",
               qif.io_count, qif.io_deq_valid, qif.io_enq_ready);
    end
    tick();
    reset = 1'b0;
    qif.io_enq_valid = 1'b1;
    qif.io_enq_bits  = 65'hA5;
    tick();
    qif.io_enq_valid = 1'b0;
    test_drain(65'hA4, 1);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    test_reset();
    test_fill(65'h0);
    test_drain(65'h0, 5);
    test_wrap();
    test_full_simul();
    test_flush();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Watchdog so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL watchdog time limit reached run=%0d", tests_run);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/data_queue_5x65.md
DATA_QUEUE_5X65 -- requirements
Module: data_queue_5x65

Interface
REQ-001 Parameter: DEPTH, 5, queue entries; SHALL equal the storage row count; not overridable.
REQ-002 Parameter: WIDTH, 65, entry width in bits; not overridable.
REQ-003 clock  in  1  sole clock; all state updates on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 io_enq_valid  in  1  producer offers io_enq_bits.
REQ-006 io_enq_ready  out  1  queue accepts an entry this cycle.
REQ-007 io_enq_bits  in  65  entry to write.
REQ-008 io_deq_valid  out  1  head entry present on io_deq_bits.
REQ-009 io_deq_ready  in  1  consumer takes head this cycle.
REQ-010 io_deq_bits  out  65  head entry; defined only while io_deq_valid=1.
REQ-011 io_flush  in  1  synchronous discard of all entries.
REQ-012 io_count  out  3  current occupancy, 0..5.

Function
REQ-013 The block SHALL be a 5-entry FIFO whose storage is a synchronous-write, combinational-read 5x65 RAM instance.
REQ-014 State: head pointer (3b), tail pointer (3b), count (3b); pointers SHALL range 0..4 and wrap 4->0, never reaching 5..7.
REQ-015 enq fire = io_enq_valid & io_enq_ready; deq fire = io_deq_valid & io_deq_ready.
REQ-016 io_enq_ready SHALL be 1 iff count<5 and io_flush=0, combinationally; it SHALL NOT depend on io_deq_ready (no full-queue pass-through).
REQ-017 io_deq_valid SHALL be 1 iff count>0 and io_flush=0; no empty-queue bypass (an entry enqueued into an empty queue appears on io_deq_bits the next cycle).
REQ-018 On enq fire: RAM write at tail, tail advances by one with wrap.
REQ-019 On deq fire: head advances by one with wrap.
REQ-020 RAM read address SHALL be head and read enable SHALL equal io_deq_valid; io_deq_bits SHALL be the RAM read data (zero-latency combinational read).
REQ-021 count next = count + enq fire - deq fire; simultaneous enq+deq SHALL leave count unchanged and advance both pointers.
REQ-022 Full (count=5): deq allowed; enq blocked that cycle even if deq fires.
REQ-023 Empty (count=0): io_deq_valid=0; io_deq_ready ignored; enq accepted.
REQ-024 io_flush=1 SHALL take priority: next head=tail=0, count=0, no RAM write, no enq or deq fire that cycle.
REQ-025 io_count SHALL equal registered count (no combinational path from inputs).
REQ-026 A write to the tail row SHALL never alias the head row while count>0 (guaranteed by the full rule); no RAM read-during-write hazard SHALL exist on visible data.

Reset
REQ-027 reset=1 SHALL asynchronously force head=0, tail=0, count=0; hence io_enq_ready=1, io_deq_valid=0, io_count=0 while reset is asserted.
REQ-028 RAM contents SHALL NOT be reset; stale rows are unreachable because count=0.
REQ-029 Reset asserted mid-operation SHALL discard all entries; the first post-reset enqueue SHALL be written to row 0.

Structure
REQ-030 A shared package SHALL hold DEPTH=5, WIDTH=65, PTR_W=3, CNT_W=3 and a pointer-increment-with-wrap function.
REQ-031 The single sub-module SHALL be the 5x65 storage RAM (ram_data_5x65), with clock driving both of its port clocks; the control logic SHALL be flat in data_queue_5x65.
REQ-032 Only head, tail and count SHALL be flops in the control logic; no other state.

Verification
REQ-033 Post-reset: enqueue 0x0_0000_0000_0000_0001..0x5 on consecutive cycles with io_deq_ready=0 -> io_count 1..5, io_enq_ready=0 after the 5th, 6th offer not accepted.
REQ-034 From full, hold io_deq_ready=1 for 5 cycles -> io_deq_bits 0x1,0x2,0x3,0x4,0x5 in order, io_deq_valid=0 and io_count=0 afterwards.
REQ-035 Wrap: enqueue 3, dequeue 3, then enqueue 0x1_FFFF_FFFF_FFFF_FFFF x5 (bit 64 set) -> tail wraps 4->0, all 5 dequeued bit-exact, no 0x0 or X on io_deq_bits.
REQ-036 Full with io_enq_valid=1 and io_deq_ready=1 for one cycle -> one dequeue, no enqueue, io_count 5->4; next cycle the enqueue is accepted, io_count=5.
REQ-037 Count=3 with io_flush=1, io_enq_valid=1 and io_deq_ready=1 -> io_enq_ready=0 and io_deq_valid=0 that cycle, io_count=0 next cycle, the following enqueue reads back correctly.
REQ-038 Assert reset asynchronously mid-cycle at count=4 -> io_count=0, io_deq_valid=0 immediately, without waiting for a clock edge; after release, enqueue 0xA5 -> dequeued as 0xA5.
